// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory pins around mem_port_arbiter.
// slave is the arbiter side; master is the requesters plus the memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_ack;
    logic [31:0]           i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [1:0]            d_mode;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [31:0]           d_wdata;
    logic                  d_ack;
    logic [31:0]           d_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_din;
    logic [1:0]            mem_mode;
    logic                  mem_str;
    logic                  mem_ld;
    logic                  mem_sel;
    logic [31:0]           mem_dout;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_mode, d_addr, d_wdata, mem_dout,
        output i_ack, i_rdata, d_ack, d_rdata,
               mem_addr, mem_din, mem_mode, mem_str, mem_ld, mem_sel
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_mode, d_addr, d_wdata, mem_dout,
        input  i_ack, i_rdata, d_ack, d_rdata,
               mem_addr, mem_din, mem_mode, mem_str, mem_ld, mem_sel
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D): D has priority, a streak limiter
// forces an I grant after STARVE_LIMIT D grants. Define ARB_PERF_CNT_EN to add perf counters.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               clr,
    mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]       perf_i_grants,
    output logic [15:0]       perf_d_grants,
    output logic [15:0]       perf_wait_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t                state, state_nxt;
    logic                  gnt_d, gnt_d_nxt;
    logic                  rd, rd_nxt;
    logic [3:0]            streak, streak_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [31:0]           din_q, din_nxt;
    logic [1:0]            mode_q, mode_nxt;
    logic                  str_q, str_nxt;
    logic                  ld_q, ld_nxt;
    logic                  sel_q, sel_nxt;
    logic                  i_ack_q, i_ack_nxt;
    logic                  d_ack_q, d_ack_nxt;

    logic any_req;
    logic pick_d;

    assign any_req = bus.i_req || bus.d_req;
    assign pick_d  = bus.d_req && !(bus.i_req && streak == LIMIT);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            gnt_d   <= 1'b0;
            rd      <= 1'b0;
            streak  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            mode_q  <= '0;
            str_q   <= 1'b0;
            ld_q    <= 1'b0;
            sel_q   <= 1'b0;
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt_d   <= gnt_d_nxt;
            rd      <= rd_nxt;
            streak  <= streak_nxt;
            addr_q  <= addr_nxt;
            din_q   <= din_nxt;
            mode_q  <= mode_nxt;
            str_q   <= str_nxt;
            ld_q    <= ld_nxt;
            sel_q   <= sel_nxt;
            i_ack_q <= i_ack_nxt;
            d_ack_q <= d_ack_nxt;
        end
    end

    // Memory pin registers are only loaded on the IDLE->ACCESS step, so they read 0 elsewhere.
    always_comb begin
        state_nxt  = state;
        gnt_d_nxt  = gnt_d;
        rd_nxt     = rd;
        streak_nxt = streak;
        addr_nxt   = '0;
        din_nxt    = '0;
        mode_nxt   = '0;
        str_nxt    = 1'b0;
        ld_nxt     = 1'b0;
        sel_nxt    = 1'b0;
        i_ack_nxt  = 1'b0;
        d_ack_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ACCESS;
                    if (pick_d) begin
                        gnt_d_nxt = 1'b1;
                        addr_nxt  = bus.d_addr;
                        mode_nxt  = bus.d_mode;
                        din_nxt   = bus.d_we ? bus.d_wdata : '0;
                        rd_nxt    = !bus.d_we && (bus.d_mode != 2'b11);
                        if (bus.d_mode != 2'b11) begin
                            sel_nxt = 1'b1;
                            str_nxt = bus.d_we;
                            ld_nxt  = !bus.d_we;
                        end
                        if (!bus.i_req)
                            streak_nxt = '0;
                        else if (streak != LIMIT)
                            streak_nxt = streak + 4'd1;
                    end else begin
                        gnt_d_nxt  = 1'b0;
                        addr_nxt   = bus.i_addr;
                        mode_nxt   = 2'b10;
                        rd_nxt     = 1'b1;
                        sel_nxt    = 1'b1;
                        ld_nxt     = 1'b1;
                        streak_nxt = '0;
                    end
                end
            end
            ACCESS: begin
                state_nxt = RESP;
                i_ack_nxt = !gnt_d;
                d_ack_nxt = gnt_d;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;
    assign bus.mem_mode = mode_q;
    assign bus.mem_str  = str_q;
    assign bus.mem_ld   = ld_q;
    assign bus.mem_sel  = sel_q;
    assign bus.i_ack    = i_ack_q;
    assign bus.d_ack    = d_ack_q;

    // Memory output is registered inside the memory, so it is valid during RESP and passed straight through.
    assign bus.i_rdata = i_ack_q ? bus.mem_dout : '0;
    assign bus.d_rdata = (d_ack_q && rd) ? bus.mem_dout : '0;

`ifdef ARB_PERF_CNT_EN
    logic grant_i, grant_d, waiting;

    assign grant_i = (state == IDLE) && any_req && !pick_d;
    assign grant_d = (state == IDLE) && pick_d;
    assign waiting = (bus.i_req && !i_ack_q) || (bus.d_req && !d_ack_q);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            perf_i_grants    <= '0;
            perf_d_grants    <= '0;
            perf_wait_cycles <= '0;
        end else begin
            if (grant_i && perf_i_grants != '1)
                perf_i_grants <= perf_i_grants + 16'd1;
            if (grant_d && perf_d_grants != '1)
                perf_d_grants <= perf_d_grants + 16'd1;
            if (waiting && perf_wait_cycles != '1)
                perf_wait_cycles <= perf_wait_cycles + 16'd1;
        end
    end
`endif

endmodule
